// File: rtl/alu_operand_regfile.sv
// Operand register file feeding the ALU logic units and adder: 2**ADDR_W x DATA_W flops,
// registered rs/rt read ports with stall hold, hardwired zero register and optional write bypass.
module alu_operand_regfile #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              op_valid
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] rs_sel;
    logic [DATA_W-1:0] rt_sel;
    logic              wr_ok;

    assign wr_ok = we && (wr_addr != '0);

    // Flop array rather than RAM so the whole file clears asynchronously; entry 0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs_sel = regs[rs_addr];
        if (rs_addr == '0) begin
            rs_sel = '0;
        end else if (BYPASS_EN && we && (wr_addr == rs_addr)) begin
            rs_sel = wr_data;
        end
    end

    always_comb begin
        rt_sel = regs[rt_addr];
        if (rt_addr == '0) begin
            rt_sel = '0;
        end else if (BYPASS_EN && we && (wr_addr == rt_addr)) begin
            rt_sel = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a        <= '0;
            b        <= '0;
            op_valid <= 1'b0;
        end else if (rd_en) begin
            a        <= rs_sel;
            b        <= rt_sel;
            op_valid <= 1'b1;
        end
    end

endmodule

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
- 32-entry x 32-bit register file that sits directly upstream of the 32-bit bitwise logic units (NOR/AND/OR/XOR) and the adder in the ALU datapath.
- Supplies the two operand buses a (rs) and b (rt) from registered read ports with one-cycle latency.
- Provides write-to-read bypass, a hardwired zero register, and operand hold for stalls.

Parameters:
- DATA_W, 32, operand/register width in bits.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- BYPASS_EN, 1, 1 = same-cycle write data forwarded to read outputs; 0 = read returns the pre-write value.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rd_en  input  1  capture new operands this cycle; 0 = hold outputs (stall).
- rs_addr  input  ADDR_W  read address for operand a.
- rt_addr  input  ADDR_W  read address for operand b.
- we  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- a  output  DATA_W  registered operand a (rs contents).
- b  output  DATA_W  registered operand b (rt contents).
- op_valid  output  1  a/b hold operands captured by a rd_en since reset.

Behaviour:
- Reset (asynchronous, active-high):
  - All 32 registers cleared to 0; a=0, b=0, op_valid=0, immediately on assertion, independent of clk.
  - While reset is high: writes ignored, rd_en ignored.
  - Reset asserted mid-operation discards any pending write and any captured operands.
- Write port, on rising edge when we=1 and wr_addr!=0: reg[wr_addr] <= wr_data.
  - Writes to address 0 are discarded.
  - reg[0] reads as 0 always.
- Read ports: registered, latency 1.
  - On rising edge with rd_en=1: a <= sel(rs_addr), b <= sel(rt_addr); op_valid <= 1.
  - On rising edge with rd_en=0: a, b, op_valid hold their values.
- Definition of sel(x):
  - If x==0: 0.
  - Else, if BYPASS_EN=1 and we=1 and wr_addr==x: wr_data (same-edge write forwarded).
  - Otherwise: reg[x] as held before the edge.
- rs_addr==rt_addr is legal; a and b receive identical values.
- Simultaneous write and hold (we=1, rd_en=0): the write commits; a/b unchanged, so they are not refreshed by the bypass.
- BYPASS_EN=0 with a same-address write: the read returns the old value, and the new value is visible on the next rd_en.
- No combinational path from any input to a, b or op_valid (all outputs are flops).
- Addresses are ADDR_W bits, so no out-of-range condition exists.
- Storage:
  - Flop array, reset-clearable.
  - Do not infer block RAM: the asynchronous reset clear is mandatory.

Test Plan:
- Reset behaviour: assert reset mid-cycle with a=0x12345678 -> a, b, op_valid go to 0 without a clock edge; after release, reading r5 returns 0.
- Basic write then read: write r3=0xDEADBEEF, next cycle rd_en=1 with rs=3, rt=0 -> one edge later a=0xDEADBEEF, b=0x00000000, op_valid=1.
- Zero register: we=1, wr_addr=0, wr_data=0xFFFFFFFF, then read rs=0, rt=0 -> a=b=0.
- Bypass:
  - BYPASS_EN=1: same edge we=1 with r7=0x0000FFFF and rd_en=1 with rs=7 -> a=0x0000FFFF.
  - BYPASS_EN=0, same stimulus with prior r7=0x11111111 -> a=0x11111111; the next rd_en gives 0x0000FFFF.
- Stall hold: capture a=0xA5A5A5A5, then rd_en=0 for 3 cycles while writing r(rs)=0x5A5A5A5A -> a stays 0xA5A5A5A5; the next rd_en -> a=0x5A5A5A5A.
- NOR integration: load r1=0xF0F0F0F0, r2=0x0F0F00FF; read rs=1, rt=2; feed a/b to the downstream 32-bit NOR unit -> its output is 0x00000F00.
